tof_sample_collector: RTL



---
 rtl/tof_sample_collector.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/tof_sample_collector.sv
// ---------------------------------------------------------------------------
// tof_sample_collector
//
// Sits behind the 8-channel ToF I2C comm block. Watches the per-sensor
// sample-pending flags, steers the comm block's sensor select round-robin
// to each pending sensor, captures the muxed {sensor_index, distance} word,
// tags it with the channel number and queues it in a small
// first-word-fall-through FIFO that drains over a valid/ready stream.
//
// Parameters:
//   FIFO_DEPTH    - number of 25-bit FIFO entries (power of two, 2..64)
//   SETTLE_CYCLES - clk cycles between applying a new select and sampling
//                   data_in (1..15)
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   enable     in   1 = collector runs; 0 = park in IDLE after any capture
//   ready_in   in   [7:0]  per-sensor sample-pending flags (bit i = sensor i)
//   data_in    in   [21:0] {sensor_index[5:0], distance[15:0]} of selected sensor
//   tof_index  out  [2:0]  sensor select toward the comm block
//   m_data     out  [24:0] {channel[2:0], sensor_index[5:0], distance[15:0]}
//   m_valid    out  FIFO non-empty
//   m_ready    in   downstream accept
//   fifo_level out  [log2(FIFO_DEPTH):0] current occupancy
//   drop_count out  [7:0]  saturating count of samples lost to a full FIFO
//   busy       out  FSM is in SELECT, SETTLE or CAPTURE
// ---------------------------------------------------------------------------
module tof_sample_collector #(
  parameter int FIFO_DEPTH    = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [7:0]                    ready_in,
  input  logic [21:0]                   data_in,
  output logic [2:0]                    tof_index,
  output logic [24:0]                   m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_count,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL  = LW'(FIFO_DEPTH);
  localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SELECT  = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic [2:0]    tof_index_r;
  logic [2:0]    tof_index_next_s;
  logic [3:0]    settle_cnt_r;
  logic [3:0]    settle_cnt_next_s;
  logic [2:0]    pick_s;

  logic [24:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic [LW-1:0] level_next_s;
  logic [7:0]    drop_count_r;
  logic          m_valid_r;
  logic          busy_r;

  logic          full_s;
  logic          capture_s;
  logic          push_s;
  logic          pop_s;
  logic          drop_s;

  // Round-robin pick: first set request scanning origin, origin+1, ...
  // modulo 8. The loop walks from the farthest candidate down to the origin
  // so the nearest set request is the one that sticks.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] origin);
    logic [2:0] cand;
    logic [2:0] pick;
    pick = origin;
    for (int k = 7; k >= 0; k--) begin
      cand = origin + 3'(k);
      if (req[cand]) begin
        pick = cand;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // Next-state logic for the select / settle / capture sequencer.
  always_comb begin
    state_next_s      = state_r;
    tof_index_next_s  = tof_index_r;
    settle_cnt_next_s = settle_cnt_r;
    pick_s            = rr_pick(ready_in, tof_index_r);
    case (state_r)
      ST_IDLE: begin
        settle_cnt_next_s = 4'd0;
        if (enable && (ready_in != 8'd0)) begin
          // The parked index is checked first: a sample landing on it is
          // only visible for one cycle, and its select is already applied.
          if (pick_s == tof_index_r) begin
            state_next_s = ST_SETTLE;
          end else begin
            tof_index_next_s = pick_s;
            state_next_s     = ST_SELECT;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SELECT: begin
        settle_cnt_next_s = 4'd0;
        state_next_s      = ST_SETTLE;
      end
      ST_SETTLE: begin
        // Committed once here: the flag may already have cleared upstream.
        if (settle_cnt_r == SETTLE_LAST) begin
          state_next_s = ST_CAPTURE;
        end else begin
          settle_cnt_next_s = settle_cnt_r + 4'd1;
        end
      end
      ST_CAPTURE: begin
        // tof_index stays parked on the captured sensor, so the next search
        // starts here and (its flag being cleared) effectively at index+1.
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, sensor select and settle counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      tof_index_r  <= 3'd0;
      settle_cnt_r <= 4'd0;
    end else begin
      state_r      <= state_next_s;
      tof_index_r  <= tof_index_next_s;
      settle_cnt_r <= settle_cnt_next_s;
    end
  end

  // FIFO control: push is decided on the pre-pop full flag, so a full FIFO
  // always drops and never sees a simultaneous push and pop.
  always_comb begin
    full_s    = (level_r == FULL_LEVEL);
    capture_s = (state_r == ST_CAPTURE);
    push_s    = capture_s && !full_s;
    drop_s    = capture_s && full_s;
    pop_s     = m_valid_r && m_ready;
    case ({push_s, pop_s})
      2'b10:   level_next_s = level_r + LW'(1);
      2'b01:   level_next_s = level_r - LW'(1);
      default: level_next_s = level_r;
    endcase
  end

  // FIFO storage and pointers; pointers wrap naturally at the power-of-two
  // depth and the level register tells full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 25'd0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {tof_index_r, data_in};
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r <= level_next_s;
    end
  end

  // Saturating drop counter for samples lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count_r <= 8'd0;
    end else if (drop_s && (drop_count_r != 8'hFF)) begin
      drop_count_r <= drop_count_r + 8'd1;
    end else begin
      drop_count_r <= drop_count_r;
    end
  end

  // Status flags registered from next-state values so they line up with
  // the state and level registers they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      m_valid_r <= (level_next_s != '0);
      busy_r    <= (state_next_s != ST_IDLE);
    end
  end

  assign tof_index  = tof_index_r;
  assign m_data     = mem_r[rd_ptr_r];
  assign m_valid    = m_valid_r;
  assign fifo_level = level_r;
  assign drop_count = drop_count_r;
  assign busy       = busy_r;

endmodule
